// File: rtl/credit_fifo_ctrl.sv
// rtl/credit_fifo_ctrl.sv - credit-flow FIFO controller around an external scdpram
//
// Turns one simple dual-port RAM (1-cycle registered read, old data on
// read/write collision) into a FIFO. The upstream side is credit based, the
// downstream side is valid/ready. A 2-entry output stage (out + skid) hides the
// RAM read latency so a steady stream moves at one word per cycle.
//
// Ports:
//   clock, resetn            clock and synchronous active-low reset
//   in_valid, in_data        upstream word (sent only while holding a credit)
//   credit_out               one-cycle pulse per word leaving the RAM
//   out_valid/ready/data     downstream valid/ready stream
//   ram_wren/write_addr/data RAM write port
//   ram_rden/read_addr       RAM read port request
//   ram_read_data            RAM read data, valid the cycle after ram_rden
//   fill_level               words currently held in the RAM
//   err_overflow             sticky: word arrived while the RAM was full
//
// Build option: CREDIT_FIFO_ERR_CHECK_EN enables the full check and the
// err_overflow flag; without it every in_valid is written.

module credit_fifo_ctrl #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  credit_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [WORD_WIDTH-1:0] ram_write_data,
    output logic                  ram_rden,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [WORD_WIDTH-1:0] ram_read_data,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  err_overflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  rd_pending_q;
    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [WORD_WIDTH-1:0] skid_data_q, skid_data_d;

    logic       accept;
    logic       wr_fire;
    logic       rd_fire;
    logic       xfer;
    logic [1:0] slots_used;

`ifdef CREDIT_FIFO_ERR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    logic err_q;
    assign accept       = (count_q != FULL_COUNT);
    assign err_overflow = err_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (in_valid && !accept) begin
            err_q <= 1'b1;
        end
    end
`else
    assign accept       = 1'b1;
    assign err_overflow = 1'b0;
`endif

    assign xfer    = out_valid_q && out_ready;
    assign wr_fire = in_valid && accept;

    // Output-stage slots already claimed (held or in flight), crediting the
    // slot freed by a transfer this cycle. Never exceeds 2, so 2 bits suffice.
    assign slots_used = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pending_q) - 2'(xfer);
    assign rd_fire    = (count_q != '0) && (slots_used < 2'd2);

    assign ram_wren       = wr_fire;
    assign ram_write_addr = wr_ptr_q;
    assign ram_write_data = in_data;
    assign ram_rden       = rd_fire;
    assign ram_read_addr  = rd_ptr_q;

    // A read leaves the RAM the same cycle its credit is owed, so the
    // registered read strobe doubles as the credit pulse.
    assign credit_out = rd_pending_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign fill_level = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (wr_fire && !rd_fire) begin
            count_d = count_q + 1'b1;
        end else if (!wr_fire && rd_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (xfer) begin
            if (skid_valid_q) begin
                // Older skid word goes first; returning data backfills skid.
                out_data_d   = skid_data_q;
                skid_valid_d = rd_pending_q;
                if (rd_pending_q) begin
                    skid_data_d = ram_read_data;
                end
            end else if (rd_pending_q) begin
                out_data_d = ram_read_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (rd_pending_q) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = ram_read_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = ram_read_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_pending_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_pending_q <= rd_fire;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_credit_fifo_ctrl.sv
// tb/tb_credit_fifo_ctrl.sv - self-checking bench for credit_fifo_ctrl
module tb_credit_fifo_ctrl;

    localparam int W     = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clock;
    logic          resetn;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          credit_out;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          ram_wren;
    logic [AW-1:0] ram_write_addr;
    logic [W-1:0]  ram_write_data;
    logic          ram_rden;
    logic [AW-1:0] ram_read_addr;
    logic [W-1:0]  ram_read_data;
    logic [AW:0]   fill_level;
    logic          err_overflow;

    credit_fifo_ctrl #(.WORD_WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .credit_out     (credit_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .ram_wren       (ram_wren),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_rden       (ram_rden),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data),
        .fill_level     (fill_level),
        .err_overflow   (err_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scdpram model: registered read, old data on same-address collision
    logic [W-1:0] mem [0:DEPTH-1];
    always @(posedge clock) begin
        if (ram_rden) ram_read_data <= mem[ram_read_addr];
        if (ram_wren) mem[ram_write_addr] <= ram_write_data;
    end

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];
    int           tb_credits;
    int           wr_idx, rd_idx;
    int           n_rden, n_credit, n_out;
    logic         prev_stall;
    logic [W-1:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        tb_credits = DEPTH;
        wr_idx     = 0;
        rd_idx     = 0;
        prev_stall = 1'b0;
    endtask

    // Drive inputs for one cycle and check/update the model at mid-cycle.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        @(negedge clock);
        check("credit_balance", tb_credits + int'(fill_level) + int'(credit_out), DEPTH);
        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("out_unexpected", out_valid, 0);
            else check("out_order", out_data, exp_q.pop_front());
        end
        if (ram_rden) begin
            check("rd_addr", ram_read_addr, rd_idx % DEPTH);
            rd_idx++;
            n_rden++;
        end
        if (in_valid) begin
            if (tb_credits > 0) begin
                check("wr_en", ram_wren, 1);
                check("wr_addr", ram_write_addr, wr_idx % DEPTH);
                check("wr_data", ram_write_data, in_data);
                wr_idx++;
                exp_q.push_back(in_data);
                tb_credits--;
            end else begin
                check("ovf_no_write", ram_wren, 0);
            end
        end else begin
            check("wr_idle", ram_wren, 0);
        end
        if (credit_out) begin
            n_credit++;
            tb_credits++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic rdy);
        drive(v, d, rdy);
        adv();
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (exp_q.size() > 0 || out_valid); i++) step(1'b0, '0, 1'b1);
        check("drain_empty", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        check("drain_credits", tb_credits, DEPTH);
        check("drain_fill", fill_level, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int max_fill;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        adv();
        adv();
        check("rst_out_valid", out_valid, 0);
        check("rst_fill", fill_level, 0);
        check("rst_credit", credit_out, 0);
        check("rst_err", err_overflow, 0);
        check("rst_out_data", out_data, 0);
        check("rst_rden", ram_rden, 0);
        resetn = 1'b1;

        // single word latency
        drive(1'b1, 16'hA5A5, 1'b1);
        check("t1_wren", ram_wren, 1);
        check("t1_waddr", ram_write_addr, 0);
        adv();
        drive(1'b0, '0, 1'b1);
        check("t1_rden", ram_rden, 1);
        check("t1_raddr", ram_read_addr, 0);
        check("t1_c1_valid", out_valid, 0);
        adv();
        drive(1'b0, '0, 1'b1);
        check("t1_credit", credit_out, 1);
        check("t1_c2_valid", out_valid, 0);
        adv();
        drive(1'b0, '0, 1'b1);
        check("t1_c3_valid", out_valid, 1);
        check("t1_c3_data", out_data, 16'hA5A5);
        adv();
        drive(1'b0, '0, 1'b1);
        check("t1_c4_valid", out_valid, 0);
        adv();

        // fill with consumer stalled, then release
        n_rden = 0; n_credit = 0; n_out = 0;
        for (int i = 0; i < 16; i++) step(1'b1, W'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        check("t2_fill", fill_level, 14);
        check("t2_rden", n_rden, 2);
        check("t2_credits", n_credit, 2);
        check("t2_head_valid", out_valid, 1);
        check("t2_head_data", out_data, 0);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
        check("t2_throughput", n_out, 16);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check("t2_total_credits", n_credit, 16);
        check("t2_empty", exp_q.size(), 0);

        // continuous stream, pointers wrap
        n_out = 0; sent = 0; max_fill = 0;
        for (int i = 0; i < 200 && n_out < 40; i++) begin
            logic v;
            v = (sent < 40) && (tb_credits > 0);
            drive(v, W'($urandom), 1'b1);
            if (v) sent++;
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
            adv();
        end
        check("t3_count", n_out, 40);
        check("t3_fill_max", max_fill <= 2, 1);
        check("t3_wrapped", wr_idx >= 2 * DEPTH + 1, 1);
        drain();

        // overflow
`ifdef CREDIT_FIFO_ERR_CHECK_EN
        for (int i = 0; i < 30; i++) step(tb_credits > 0, W'(16'h1000 + i), 1'b0);
        check("t4_full", fill_level, DEPTH);
        check("t4_no_credits", tb_credits, 0);
        drive(1'b1, 16'hDEAD, 1'b0);
        check("t4_dead_dropped", ram_wren, 0);
        adv();
        check("t4_err_set", err_overflow, 1);
        drain();
        check("t4_err_sticky", err_overflow, 1);
        resetn = 1'b0;
        adv();
        resetn = 1'b1;
        model_reset();
        check("t4_err_cleared", err_overflow, 0);
`else
        check("t4_err_tied", err_overflow, 0);
`endif

        // toggling ready during a burst
        n_out = 0; sent = 0;
        for (int k = 0; k < 40; k++) begin
            logic v;
            v = (sent < 10) && (tb_credits > 0);
            step(v, W'($urandom), (k % 2) == 0);
            if (v) sent++;
        end
        drain();
        check("t5_count", n_out, 10);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            logic v;
            v = ($urandom_range(1, 0) == 1) && (tb_credits > 0);
            step(v, W'($urandom), $urandom_range(2, 0) != 0);
        end
        drain();

        // reset with a read in flight
        step(1'b1, 16'h1234, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("t6_rden", ram_rden, 1);
        adv();
        resetn   = 1'b0;
        in_valid = 1'b0;
        adv();
        check("t6_out_valid", out_valid, 0);
        check("t6_fill", fill_level, 0);
        check("t6_credit", credit_out, 0);
        resetn = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            check("t6_no_out", out_valid, 0);
            check("t6_no_credit", credit_out, 0);
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/credit_fifo_ctrl.md
Name: credit_fifo_ctrl

Overview:
- Controller that turns one external scdpram instance (1 write port, 1 read port, common clock, 1-cycle registered read, old-data on read/write collision) into a credit-flow-controlled FIFO.
- Sits between a credit-based upstream producer and a valid/ready downstream consumer in the FIR datapath.
- Owns the write/read pointers, the occupancy count, credit return and a 2-entry output stage that hides RAM read latency.

Parameters:
- WORD_WIDTH, 16, data word width; must match the RAM instance.
- ADDR_WIDTH, 4, RAM address width.
- DEPTH, 2**ADDR_WIDTH, RAM entries used; 2..2**ADDR_WIDTH, power of two not required.

Ports:
- clock  in  1  single clock for the block and the RAM.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream word present; upstream may assert only while holding a credit.
- in_data  in  WORD_WIDTH  upstream word.
- credit_out  out  1  one-cycle pulse; returns one credit to upstream.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream accepts; transfer occurs when out_valid && out_ready.
- out_data  out  WORD_WIDTH  head-of-FIFO word.
- ram_wren  out  1  RAM write enable.
- ram_write_addr  out  ADDR_WIDTH  RAM write address.
- ram_write_data  out  WORD_WIDTH  RAM write data.
- ram_rden  out  1  RAM read enable.
- ram_read_addr  out  ADDR_WIDTH  RAM read address.
- ram_read_data  in  WORD_WIDTH  RAM read data, valid the cycle after ram_rden.
- fill_level  out  ADDR_WIDTH+1  words currently held in RAM (count).
- err_overflow  out  1  sticky overflow flag.

Behaviour:
- Reset (resetn=0 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, rd_pending=0, out_valid=0, skid_valid=0, credit_out=0, err_overflow=0, out_data=0.
- Reset aborts any in-flight read; returning data is discarded. Upstream re-initialises to DEPTH credits on reset.
- Write path (combinational):
  - ram_wren = in_valid && accept.
  - ram_write_addr = wr_ptr; ram_write_data = in_data.
  - accept = (count != DEPTH).
  - wr_ptr increments on each write and wraps from DEPTH-1 to 0.
- Read issue (combinational): ram_rden = (count != 0) && (out_valid + skid_valid + rd_pending < 2).
  - ram_read_addr = rd_ptr; rd_ptr increments on each read and wraps from DEPTH-1 to 0.
  - rd_pending is set for the cycle after ram_rden.
  - The slot test counts a slot freed by an out_valid && out_ready transfer in the same cycle.
- count: +1 on write, -1 on read, unchanged when both occur in the same cycle. A word written in cycle t is readable from cycle t+1, so the same address is never read and written in one cycle except at full, where the old-data behaviour is correct.
- Credit: credit_out is the ram_rden registered by one cycle; exactly one pulse per word leaving RAM. Total credits in flight plus count always equals DEPTH.
- Output stage:
  - Returning read data loads out_data if out_valid=0, or if out_valid && out_ready in that cycle (in which case the skid entry moves to out first when present); otherwise it loads skid.
  - On transfer, skid (if valid) moves into out; out_valid stays high.
  - out_data is stable while out_valid && !out_ready.
- Latency: word accepted in cycle 0 with an empty FIFO gives out_valid=1 in cycle 3.
- Throughput: 1 word/cycle sustained with out_ready held high.
- Overflow: in_valid while count==DEPTH means the word is dropped, no RAM write, and err_overflow=1 until reset. The check uses count before any same-cycle read.
- Simultaneous write and read with count==DEPTH-1 or 1: both proceed; count is unchanged.

Optional Feature:
- CREDIT_FIFO_ERR_CHECK_EN defined: overflow detection as above, err_overflow live.
- Not defined: err_overflow tied 0, accept is forced to 1, no full check; a write at full is undefined behaviour. This saves the comparator in a protocol-clean build.

Test Plan:
- Reset, then 1 word 0xA5A5 at cycle 0 with out_ready=1 -> ram_wren cycle 0 addr 0; ram_rden cycle 1 addr 0; credit_out cycle 2; out_valid with 0xA5A5 cycle 3 for 1 cycle.
- DEPTH=16, write 0..15 back-to-back with out_ready=0 -> ram_rden twice only (skid full), fill_level reaches 14, 2 credits returned; release out_ready -> 0..15 out in order, 1/cycle, 16 total credit_out pulses.
- Continuous stream of 40 words with out_ready=1 -> pointers wrap 15->0 twice; output order preserved; fill_level never exceeds 2.
- Fill to 16 with no credits, then inject in_valid with 0xDEAD (macro on) -> no ram_wren, err_overflow=1, 0xDEAD never appears on out_data.
- Toggle out_ready 1,0,1,0 during a 10-word burst -> no loss or duplication; out_data stable while stalled.
- Assert resetn=0 one cycle after ram_rden with data pending -> next cycle out_valid=0, fill_level=0, no credit_out, stale ram_read_data ignored.
